mem_dump_unit: RTL and testbench

- Memory readback engine for the RISC_SPM system: the reader counterpart to program/data loading.
- On command, it requests the memory bus from the processor and reads a contiguous address range from the memory unit.
- Each word is streamed out with its address over a valid/ready interface.
- It reports an 8-bit modular checksum on completion. Used for post-HALT result extraction and load verification.

---
 rtl/mem_dump_unit_if.sv | 40 ++++
 rtl/mem_dump_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_dump_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_unit_if.sv
// Bundle of the command, memory-bus and output-stream signals of the
// memory readback engine. The slave modport is the engine's view; the
// master modport is the view of whoever drives the commands, owns the
// memory and consumes the stream.
interface mem_dump_unit_if #(
    parameter int word_size = 8,
    parameter int addr_size = 8
);
    // command
    logic                 start;
    logic [addr_size-1:0] start_addr;
    logic [addr_size-1:0] end_addr;
    // memory bus
    logic                 bus_req;
    logic                 bus_gnt;
    logic [addr_size-1:0] mem_addr;
    logic [word_size-1:0] mem_data;
    // output stream
    logic                 dout_valid;
    logic                 dout_ready;
    logic [word_size-1:0] dout_data;
    logic [addr_size-1:0] dout_addr;
    logic                 dout_last;
    // status
    logic                 busy;
    logic                 done;
    logic [word_size-1:0] checksum;

    modport slave (
        input  start, start_addr, end_addr, bus_gnt, mem_data, dout_ready,
        output bus_req, mem_addr, dout_valid, dout_data, dout_addr, dout_last,
               busy, done, checksum
    );

    modport master (
        output start, start_addr, end_addr, bus_gnt, mem_data, dout_ready,
        input  bus_req, mem_addr, dout_valid, dout_data, dout_addr, dout_last,
               busy, done, checksum
    );
endinterface

// File: rtl/mem_dump_unit.sv
// Memory readback engine: on a start command it requests the memory bus,
// reads an inclusive (wrapping) address range one word at a time, streams
// each word with its address over valid/ready and reports a modular sum
// of everything sent. All outputs are registered from the next state.
module mem_dump_unit #(
    parameter int word_size = 8,
    parameter int addr_size = 8
) (
    input  logic            clk,
    input  logic            rst,
    mem_dump_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_READ = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [addr_size-1:0] ADDR_ZERO = {addr_size{1'b0}};
    localparam logic [addr_size-1:0] ADDR_ONE  = {{(addr_size-1){1'b0}}, 1'b1};
    localparam logic [word_size-1:0] WORD_ZERO = {word_size{1'b0}};
    localparam logic [addr_size:0]   CNT_ZERO  = {(addr_size+1){1'b0}};
    localparam logic [addr_size:0]   CNT_ONE   = {{addr_size{1'b0}}, 1'b1};

    // Words in the inclusive range; the extra bit lets a full wrap be 2^addr_size.
    function automatic logic [addr_size:0] word_count(
        input logic [addr_size-1:0] first,
        input logic [addr_size-1:0] last
    );
        logic [addr_size-1:0] span;
        span = last - first;
        return {1'b0, span} + CNT_ONE;
    endfunction

    // Running checksum, modulo 2^word_size.
    function automatic logic [word_size-1:0] sum_add(
        input logic [word_size-1:0] acc,
        input logic [word_size-1:0] word
    );
        return acc + word;
    endfunction

    state_t               state_q,      state_d;
    logic [addr_size-1:0] cur_addr_q,   cur_addr_d;
    logic [addr_size:0]   remaining_q,  remaining_d;
    logic [word_size-1:0] data_q,       data_d;
    logic [addr_size-1:0] daddr_q,      daddr_d;
    logic                 last_q,       last_d;
    logic [word_size-1:0] checksum_q,   checksum_d;
    logic                 bus_req_q,    bus_req_d;
    logic [addr_size-1:0] mem_addr_q,   mem_addr_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;

    // Next-state, datapath updates and next-output decode.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        daddr_d     = daddr_q;
        last_d      = last_q;
        checksum_d  = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cur_addr_d  = bus.start_addr;
                    remaining_d = word_count(bus.start_addr, bus.end_addr);
                    checksum_d  = WORD_ZERO;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.bus_gnt) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_READ: begin
                // Without the grant the read data is meaningless: nothing is
                // captured and the same address is retried after re-grant.
                if (bus.bus_gnt) begin
                    data_d  = bus.mem_data;
                    daddr_d = cur_addr_q;
                    last_d  = (remaining_q == CNT_ONE);
                    state_d = S_SEND;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_SEND: begin
                if (bus.dout_ready) begin
                    checksum_d  = sum_add(checksum_q, data_q);
                    cur_addr_d  = cur_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (bus.bus_gnt) begin
                        state_d = S_READ;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        bus_req_d    = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_SEND);
        dout_valid_d = (state_d == S_SEND);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        if (state_d == S_READ) begin
            mem_addr_d = cur_addr_d;
        end else begin
            mem_addr_d = ADDR_ZERO;
        end
    end

    // State, datapath and output registers; reset abandons any dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= ADDR_ZERO;
            remaining_q  <= CNT_ZERO;
            data_q       <= WORD_ZERO;
            daddr_q      <= ADDR_ZERO;
            last_q       <= 1'b0;
            checksum_q   <= WORD_ZERO;
            bus_req_q    <= 1'b0;
            mem_addr_q   <= ADDR_ZERO;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            data_q       <= data_d;
            daddr_q      <= daddr_d;
            last_q       <= last_d;
            checksum_q   <= checksum_d;
            bus_req_q    <= bus_req_d;
            mem_addr_q   <= mem_addr_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.bus_req    = bus_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_data  = data_q;
    assign bus.dout_addr  = daddr_q;
    assign bus.dout_last  = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.checksum   = checksum_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Testbench for mem_dump_unit: directed table of dumps, hand-written
// reset sequence, then randomized ranges with random grant/ready,
// checked against an address-list / checksum model built from the memory.
module tb_mem_dump_unit;

    logic clk;
    logic rst;
    logic [7:0] mem [256];

    mem_dump_unit_if #(.word_size(8), .addr_size(8)) ifc ();

    assign ifc.mem_data = mem[ifc.mem_addr];

    mem_dump_unit #(.word_size(8), .addr_size(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } word_t;
    word_t exp_q[$];

    typedef struct {
        logic [7:0] sa;
        logic [7:0] ea;
        int         rmode;   // 0 tied high, 1 pattern 0,0,1 per word, 2 random
        int         gmode;   // 0 tied high, 1 delayed then dropped, 2 random
        int         ck;      // expected checksum, -1 = from model
        bit         inj;     // extra start pulse while busy
        string      name;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic run_dump(input logic [7:0] sa, input logic [7:0] ea,
                            input int rmode, input int gmode, input int exp_ck,
                            input bit inj, input string tag);
        int n, sum, k, drop_left, xfers;
        bit prev_valid, prev_xfer, got_done, seen_valid, xfer;
        logic [7:0] pd, pa;
        logic pl;
        logic [7:0] a;
        word_t e;

        // Reference: the inclusive wrapping range and its modular sum.
        exp_q.delete();
        n = ((int'(ea) - int'(sa)) & 255) + 1;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            a = 8'(int'(sa) + i);
            exp_q.push_back('{a, mem[a]});
            sum = (sum + int'(mem[a])) % 256;
        end
        if (exp_ck >= 0) sum = exp_ck;

        k = 0; drop_left = 0; xfers = 0;
        prev_valid = 0; prev_xfer = 0; got_done = 0; seen_valid = 0;
        pd = 8'h00; pa = 8'h00; pl = 1'b0;

        @(posedge clk); #1;
        ifc.start      = 1'b1;
        ifc.start_addr = sa;
        ifc.end_addr   = ea;
        ifc.dout_ready = 1'b0;
        ifc.bus_gnt    = (gmode == 1) ? 1'b0 : 1'b1;

        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(posedge clk); #1;
            ifc.start = (inj && cyc == 2);
            if (inj && cyc == 2) begin
                ifc.start_addr = sa + 8'd7;
                ifc.end_addr   = sa + 8'd9;
            end
            case (gmode)
                0: ifc.bus_gnt = 1'b1;
                1: begin
                    if (cyc <= 5) ifc.bus_gnt = 1'b0;
                    else if (drop_left > 0) begin
                        ifc.bus_gnt = 1'b0;
                        drop_left--;
                    end else ifc.bus_gnt = 1'b1;
                end
                default: ifc.bus_gnt = ($urandom_range(0, 3) != 0);
            endcase
            case (rmode)
                0: ifc.dout_ready = 1'b1;
                1: begin
                    if (ifc.dout_valid) begin
                        ifc.dout_ready = (k >= 2);
                        k++;
                    end else ifc.dout_ready = 1'b0;
                end
                default: ifc.dout_ready = $urandom_range(0, 1);
            endcase

            @(negedge clk);
            chk(tag, "busy", ifc.busy, 1);
            chk(tag, "bus_req", ifc.bus_req, !ifc.done);
            if (ifc.dout_valid && !seen_valid) begin
                seen_valid = 1;
                if (gmode == 0) chk(tag, "first_valid_latency", cyc, 3);
            end
            if (prev_valid && !prev_xfer && ifc.dout_valid) begin
                chk(tag, "hold_data", ifc.dout_data, pd);
                chk(tag, "hold_addr", ifc.dout_addr, pa);
                chk(tag, "hold_last", ifc.dout_last, pl);
            end
            xfer = ifc.dout_valid && ifc.dout_ready;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    chk(tag, "extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(tag, "word_addr", ifc.dout_addr, e.addr);
                    chk(tag, "word_data", ifc.dout_data, e.data);
                    chk(tag, "word_last", ifc.dout_last, exp_q.size() == 0);
                end
                xfers++;
                if (gmode == 1 && xfers == 1) drop_left = 3;
                k = 0;
            end
            if (ifc.done) begin
                got_done = 1;
                chk(tag, "done_after_last", prev_xfer && exp_q.size() == 0, 1);
                chk(tag, "checksum", ifc.checksum, sum);
                chk(tag, "valid_in_done", ifc.dout_valid, 0);
                chk(tag, "mem_addr_in_done", ifc.mem_addr, 0);
                break;
            end
            prev_valid = ifc.dout_valid;
            prev_xfer  = xfer;
            pd = ifc.dout_data;
            pa = ifc.dout_addr;
            pl = ifc.dout_last;
        end
        if (!got_done) chk(tag, "timeout_no_done", 0, 1);

        @(posedge clk); #1;
        ifc.start      = 1'b0;
        ifc.dout_ready = 1'b0;
        @(negedge clk);
        chk(tag, "done_one_cycle", ifc.done, 0);
        chk(tag, "busy_after", ifc.busy, 0);
        chk(tag, "checksum_held", ifc.checksum, sum);
    endtask

    initial begin
        rst = 1'b0;
        ifc.start = 1'b0;
        ifc.start_addr = 8'h00;
        ifc.end_addr = 8'h00;
        ifc.bus_gnt = 1'b0;
        ifc.dout_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[128] = 8'd5;   mem[129] = 8'd6;   mem[130] = 8'd7;
        mem[254] = 8'hF0;  mem[255] = 8'h20;  mem[0] = 8'h51; mem[1] = 8'h03;
        mem[139] = 8'hF0;

        repeat (3) @(negedge clk);
        chk("reset", "bus_req", ifc.bus_req, 0);
        chk("reset", "dout_valid", ifc.dout_valid, 0);
        chk("reset", "busy", ifc.busy, 0);
        chk("reset", "done", ifc.done, 0);
        chk("reset", "checksum", ifc.checksum, 0);
        chk("reset", "mem_addr", ifc.mem_addr, 0);
        rst = 1'b1;

        vecs[0] = '{8'd128, 8'd130, 0, 0, 18,    0, "basic"};
        vecs[1] = '{8'd128, 8'd130, 1, 0, 18,    0, "backpressure"};
        vecs[2] = '{8'd254, 8'd1,   0, 0, 'h64,  0, "wrap"};
        vecs[3] = '{8'd139, 8'd139, 0, 0, 'hF0,  1, "single_busy_start"};
        vecs[4] = '{8'd128, 8'd130, 0, 1, 18,    0, "grant_loss"};
        for (int v = 0; v < 5; v++)
            run_dump(vecs[v].sa, vecs[v].ea, vecs[v].rmode, vecs[v].gmode,
                     vecs[v].ck, vecs[v].inj, vecs[v].name);

        // Reset during the second SEND of 128..130.
        @(posedge clk); #1;
        ifc.start = 1'b1; ifc.start_addr = 8'd128; ifc.end_addr = 8'd130;
        ifc.bus_gnt = 1'b1; ifc.dout_ready = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_mid", "second_valid", ifc.dout_valid, 1);
        chk("rst_mid", "second_addr", ifc.dout_addr, 8'd129);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid", "bus_req", ifc.bus_req, 0);
        chk("rst_mid", "mem_addr", ifc.mem_addr, 0);
        chk("rst_mid", "dout_valid", ifc.dout_valid, 0);
        chk("rst_mid", "dout_data", ifc.dout_data, 0);
        chk("rst_mid", "dout_addr", ifc.dout_addr, 0);
        chk("rst_mid", "dout_last", ifc.dout_last, 0);
        chk("rst_mid", "busy", ifc.busy, 0);
        chk("rst_mid", "checksum", ifc.checksum, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid", "no_done", ifc.done, 0);
        end
        rst = 1'b1;
        run_dump(8'd129, 8'd129, 0, 0, 6, 0, "after_reset");

        // Randomized ranges against the model.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 25; t++) begin
            logic [7:0] sa, ea;
            sa = 8'($urandom);
            ea = sa + 8'($urandom_range(0, 11));
            run_dump(sa, ea, 2, 2, -1, 0, "random");
        end
        run_dump(8'd37, 8'd36, 0, 0, -1, 0, "full_range");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
